stream_frame_tx: RTL
====================

// Module: stream_frame_tx
// PURPOSE
//  Byte-stream frame transmitter: the source end of the 8-bit valid/ready/last stream link.
//  Host loads up to DEPTH bytes through a simple write port, then pulses start.
//  The block emits the frame one byte per accepted handshake, asserting last on the final byte.
//  Sits upstream of the stream skid buffer and drives its master-side inputs.
// PARAMETERS
//  DEPTH   16  frame buffer size in bytes (power of two, >=2)
//  ADDR_W  4   log2(DEPTH); count registers are ADDR_W+1 bits wide
// PORTS
//  clk       in   1  clock, all logic on rising edge
//  reset     in   1  asynchronous, active-low reset
//  wr_en     in   1  write one byte into the frame buffer
//  wr_data   in   8  byte to write
//  wr_err    out  1  one-cycle pulse: write dropped (busy, full, or same cycle as start)
//  start     in   1  launch transmission of the buffered frame
//  busy      out  1  frame in flight (SEND or CHK state)
//  done      out  1  one-cycle pulse after the last byte handshake
//  tx_data   out  8  stream data
//  tx_valid  out  1  stream valid
//  tx_last   out  1  marks final byte of the frame
//  tx_ready  in   1  downstream ready
// BEHAVIOUR
//  Reset (reset=0, async): wr_err=0, busy=0, done=0, tx_data=0, tx_valid=0, tx_last=0;
//   wr_count=0, rd_ptr=0, state=IDLE. Reset mid-frame aborts it; buffered bytes are discarded.
//  All outputs are registered. The buffer read is combinational, which allows a registered prefetch.
//  Writes: accepted only in IDLE with wr_count<DEPTH and start=0. Byte goes to mem[wr_count],
//   then wr_count+1. In every other case the write is dropped and wr_err pulses for one cycle.
//  FSM IDLE: start=1 with wr_count!=0 -> SEND. Next cycle: tx_valid=1, tx_data=mem[0],
//   tx_last=(wr_count==1 && no checksum). start with wr_count==0 is ignored (no err, no done).
//  FSM SEND: a handshake is tx_valid&&tx_ready. On a handshake of a non-final byte, load
//   mem[rd_ptr+1] and rd_ptr+1. Throughput is 1 byte/cycle while tx_ready stays high.
//   After the final byte handshake: IDLE (or CHK, see CONFIGURATION).
//  Stability rule: while tx_valid=1 and tx_ready=0, tx_data and tx_last hold.
//   tx_valid never drops without a handshake. tx_valid does not depend on tx_ready.
//  Completion: on the cycle after the final handshake, tx_valid=0, tx_last=0, done=1 (one cycle),
//   wr_count=0, rd_ptr=0, busy=0. A new start is legal from that cycle.
//  start while busy is ignored. wr_count==DEPTH is full: further writes pulse wr_err.
//  rd_ptr never wraps; the final byte is detected by rd_ptr==wr_count-1.
// CONFIGURATION
//  Macro STREAM_TX_CHECKSUM_EN.
//  When defined: CHK state is added. After the final payload byte handshake, one extra byte is sent.
//   It is the XOR of all payload bytes and is accumulated on each payload handshake.
//   tx_last=1 only on the checksum byte. done pulses after the checksum handshake.
//   The accumulator clears at start and on reset.
//  When undefined: no CHK state, no accumulator, tx_last is on the last payload byte.
// STRUCTURE
//  Package stream_pkg:
//   - STREAM_DW=8
//   - state localparams ST_IDLE=2'd0, ST_SEND=2'd1, ST_CHK=2'd2
//   - the stream handshake helper macro (fire = valid & ready)
//  Sub-module frame_buf_mem (DEPTH x 8 register array):
//   - synchronous write port and combinational read port
//   - no reset on the array
//  Top level holds the FSM, counters, output registers and the optional checksum.
// TESTING
//  1. Write 0x11,0x22,0x33; start; tx_ready=1 -> bytes on 3 consecutive cycles, last on 0x33;
//     done on the next cycle.
//  2. Same frame with tx_ready toggling 1,0,0,1,0,1 -> data/last held during stalls;
//     each byte is emitted once, in order; no valid drop.
//  3. Write 17 bytes with DEPTH=16 -> 17th write pulses wr_err; frame is 16 bytes, last on byte 15.
//  4. wr_en during SEND, and start with wr_count==0 -> wr_err pulse, stream unaffected;
//     the empty start produces no tx_valid and no done.
//  5. Assert reset after byte 1 of a 4-byte frame -> all outputs 0 immediately;
//     after release, start with no writes gives no output.
//  6. With STREAM_TX_CHECKSUM_EN, frame 0xA5,0x0F -> 0xA5, 0x0F, then 0xAA with last=1;
//     done after the 0xAA handshake.

Source files
------------

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared stream width, FSM state encoding and handshake helper
`ifndef STREAM_PKG_SV
`define STREAM_PKG_SV

`define STREAM_FIRE(valid, ready) ((valid) & (ready))

package stream_pkg;

  localparam int STREAM_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CHK  = 2'd2
  } state_t;

endpackage

`endif

// File: rtl/frame_buf_mem.sv
// rtl/frame_buf_mem.sv - DEPTH x 8 frame buffer, synchronous write, combinational read
module frame_buf_mem
  import stream_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [STREAM_DW-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [STREAM_DW-1:0] rdata
);

  logic [STREAM_DW-1:0] mem [DEPTH];

  // Contents are only meaningful below wr_count, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_frame_tx.sv
// rtl/stream_frame_tx.sv - buffered byte-frame transmitter onto a valid/ready/last stream
// Optional trailing XOR checksum byte enabled by STREAM_TX_CHECKSUM_EN.
module stream_frame_tx
  import stream_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [STREAM_DW-1:0] wr_data,
  output logic                 wr_err,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [STREAM_DW-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 tx_last,
  input  logic                 tx_ready
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

`ifdef STREAM_TX_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
  logic [STREAM_DW-1:0] chk_q, chk_d;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  state_t               state_q, state_d;
  logic [ADDR_W:0]      wr_count_q, wr_count_d;
  logic [ADDR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [STREAM_DW-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 tx_last_q, tx_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wr_err_q, wr_err_d;

  logic                 wr_ok;
  logic                 fire;
  logic                 last_beat;
  logic [ADDR_W:0]      rd_next;
  logic [ADDR_W-1:0]    rd_addr;
  logic [STREAM_DW-1:0] rd_data;

  assign fire      = `STREAM_FIRE(tx_valid_q, tx_ready);
  assign rd_next   = rd_ptr_q + CNT_ONE;
  assign last_beat = (rd_ptr_q == wr_count_q - CNT_ONE);
  assign wr_ok     = wr_en && (state_q == ST_IDLE) && !wr_count_q[ADDR_W] && !start;
  // Prefetch address: byte 0 while idle, the following byte while sending.
  assign rd_addr   = (state_q == ST_SEND) ? rd_next[ADDR_W-1:0] : '0;

  frame_buf_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_count_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wr_err_d   = wr_en && !wr_ok;
`ifdef STREAM_TX_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    if (wr_ok) begin
      wr_count_d = wr_count_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && (wr_count_q != '0)) begin
          state_d    = ST_SEND;
          busy_d     = 1'b1;
          rd_ptr_d   = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = rd_data;
          tx_last_d  = !CHK_EN && (wr_count_q == CNT_ONE);
`ifdef STREAM_TX_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      ST_SEND: begin
        if (fire) begin
`ifdef STREAM_TX_CHECKSUM_EN
          chk_d = chk_q ^ tx_data_q;
`endif
          if (!last_beat) begin
            rd_ptr_d  = rd_next;
            tx_data_d = rd_data;
            tx_last_d = !CHK_EN && (rd_next == wr_count_q - CNT_ONE);
          end else begin
`ifdef STREAM_TX_CHECKSUM_EN
            state_d   = ST_CHK;
            tx_data_d = chk_q ^ tx_data_q;
            tx_last_d = 1'b1;
`else
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            done_d     = 1'b1;
            wr_count_d = '0;
            rd_ptr_d   = '0;
`endif
          end
        end
      end
`ifdef STREAM_TX_CHECKSUM_EN
      ST_CHK: begin
        if (fire) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          done_d     = 1'b1;
          wr_count_d = '0;
          rd_ptr_d   = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_count_q <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
`ifdef STREAM_TX_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_err_q   <= wr_err_d;
`ifdef STREAM_TX_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign wr_err   = wr_err_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;

endmodule
